// File: rtl/div_seq_16bit_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_seq_16bit_pkg;

    // Default operand / quotient / remainder width.
    localparam int DIV_WIDTH = 16;

    // Iteration counter width for the default operand width.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : div_seq_16bit_pkg

// File: rtl/div_seq_16bit_trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtractor a - b.
// It is built from 4-bit add/sub slices with B inverted and carry-in 1.
// The top bit only needs a carry stage. When there is no borrow, the
// difference is smaller than the divisor, so its top bit is always zero
// and the top bit is not exported.
module div_trial_sub
    import div_seq_16bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NSLICE = WIDTH / 4;

    logic [NSLICE:0] carry_s;
    logic            carry_out_s;

    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        assign {carry_s[i+1], diff[4*i +: 4]} = {1'b0, a[4*i +: 4]}
                                              + {1'b0, ~b[4*i +: 4]}
                                              + {4'b0000, carry_s[i]};
    end

    // Carry of the single top bit: a[WIDTH] + ~b[WIDTH] + carry in.
    assign carry_out_s = (a[WIDTH] & ~b[WIDTH])
                       | ((a[WIDTH] | ~b[WIDTH]) & carry_s[NSLICE]);
    assign borrow      = ~carry_out_s;

endmodule : div_trial_sub

// File: rtl/div_seq_16bit.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// It produces one quotient bit per clock. A zero divisor finishes in one cycle.
module div_seq_16bit
    import div_seq_16bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_r, state_next_s;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] dvd_sr_r;
    logic [WIDTH-1:0] dvs_r;
    // The accepted partial remainder is always below the divisor, so WIDTH
    // bits hold it. The trial value is WIDTH+1 bits wide.
    logic [WIDTH-1:0] rem_acc_r;
    logic [WIDTH:0]   r_trial_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] rem_next_s;
    logic             q_bit_s;
    logic             accept_s;
    logic             busy_r, done_r, busy_next_s, done_next_s;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             div_by_zero_r;

    assign r_trial_s  = {rem_acc_r, dvd_sr_r[WIDTH-1]};
    assign q_bit_s    = ~borrow_s;
    assign rem_next_s = borrow_s ? r_trial_s[WIDTH-1:0] : diff_s;
    assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));

    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .a      (r_trial_s),
        .b      ({1'b0, dvs_r}),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic. DONE accepts a new start exactly like IDLE does.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = (divisor == {WIDTH{1'b0}}) ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == LAST_CNT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state and then registered.
    always_comb begin
        busy_next_s = (state_next_s == CALC);
        done_next_s = (state_next_s == DONE);
    end

    // Registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Datapath: operand capture, one restoring step per cycle, result write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r       <= {CNT_W{1'b0}};
            dvd_sr_r      <= {WIDTH{1'b0}};
            dvs_r         <= {WIDTH{1'b0}};
            rem_acc_r     <= {WIDTH{1'b0}};
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
        end else if (accept_s) begin
            if (divisor == {WIDTH{1'b0}}) begin
                quotient_r    <= {WIDTH{1'b1}};
                remainder_r   <= dividend;
                div_by_zero_r <= 1'b1;
            end else begin
                dvd_sr_r  <= dividend;
                dvs_r     <= divisor;
                rem_acc_r <= {WIDTH{1'b0}};
                count_r   <= {CNT_W{1'b0}};
            end
        end else if (state_r == CALC) begin
            rem_acc_r <= rem_next_s;
            dvd_sr_r  <= {dvd_sr_r[WIDTH-2:0], q_bit_s};
            count_r   <= count_r + CNT_W'(1);
            if (count_r == LAST_CNT) begin
                quotient_r    <= {dvd_sr_r[WIDTH-2:0], q_bit_s};
                remainder_r   <= rem_next_s;
                div_by_zero_r <= 1'b0;
            end else begin
                div_by_zero_r <= div_by_zero_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;

endmodule : div_seq_16bit

// File: tb/tb_div_seq_16bit.sv
// Self-checking bench for div_seq_16bit: directed table, corner sequences,
// and a random sweep against a behavioural reference.
module tb_div_seq_16bit;
    import div_seq_16bit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq_16bit #(.WIDTH(DIV_WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation in the next cycle and wait (bounded) for done.
    // The latency is the number of rising edges after the start edge until
    // done is visible.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input int elat);
        int k;
        int busy_cnt;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 16'h0000;
        k        = 0;
        busy_cnt = 0;
        if (b != 16'h0000) chk("done_single_pulse", {31'd0, done}, 32'd0);
        while (!done && k < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", k, elat);
        chk("busy_cycles", busy_cnt, (b == 16'h0000) ? 0 : 16);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {16'd0, remainder}, {16'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    vec_t vecs[9];

    initial begin
        int  k;
        bit  seen;
        logic [15:0] ra, rb;

        vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 16};
        vecs[1] = '{16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1, 0};
        vecs[2] = '{16'd10,    16'd5,     16'd2,     16'd0,     1'b0, 16};
        vecs[3] = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0, 16};
        vecs[4] = '{16'd5,     16'd9,     16'd0,     16'd5,     1'b0, 16};
        vecs[5] = '{16'h8000,  16'hFFFF,  16'h0000,  16'h8000,  1'b0, 16};
        vecs[6] = '{16'hFFFF,  16'hFFFF,  16'h0001,  16'h0000,  1'b0, 16};
        vecs[7] = '{16'h0000,  16'h0005,  16'h0000,  16'h0000,  1'b0, 16};
        vecs[8] = '{16'h7FFF,  16'h0100,  16'h007F,  16'h00FF,  1'b0, 16};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'h0000;
        divisor  = 16'h0000;
        #23;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
        end

        // Let done drop and check that the controller returns to idle.
        @(posedge clk);
        #1;
        chk("idle_done_low", {31'd0, done}, 32'd0);
        chk("idle_busy_low", {31'd0, busy}, 32'd0);

        // A start that arrives while the divider is calculating is ignored.
        @(negedge clk);
        start = 1'b1; dividend = 16'd200; divisor = 16'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 16'd50; divisor = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
        k = 5;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ignored_start_latency", k, 16);
        chk("ignored_start_q", {16'd0, quotient}, 32'd22);
        chk("ignored_start_r", {16'd0, remainder}, 32'd2);
        // Back-to-back: issue the new start during the DONE cycle.
        run_op(16'd50, 16'd3, 16'd16, 16'd2, 1'b0, 16);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_q", {16'd0, quotient}, 32'd0);
        chk("async_rst_r", {16'd0, remainder}, 32'd0);
        chk("async_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("no_activity_after_reset", {31'd0, seen}, 32'd0);
        run_op(16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 16);

        // Random sweep with back-to-back starts.
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 1) rb = 16'($urandom_range(1, 255));
            if (rb == 16'h0000) rb = 16'h0001;
            run_op(ra, rb, ra / rb, ra % rb, 1'b0, 16);
        end
        @(posedge clk);
        #1;
        chk("final_done_low", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_seq_16bit
